// File: rtl/ripple_carry_adder_subtractor.sv
// Two's-complement adder/subtractor built from an explicit ripple chain of
// full adders, with registered outputs and a one-cycle latency.
// When ctrl=1, B is inverted and the chain carry-in is 1, which gives A - B.
// Cout is the raw carry out of the MSB stage. It is never turned into a borrow.
// Optional feature: define RCAS_OVERFLOW_EN to add a registered signed-overflow
// output named Overflow.

module rcas_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module ripple_carry_adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ctrl,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
`ifdef RCAS_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic             out_valid
);

    // Effective B operand and carry chain. carry[0] is the chain carry-in.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             valid_reg;

    assign carry[0] = ctrl;

    // One full-adder stage per bit. The carry ripples from the LSB upward.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            assign b_eff[gi] = B[gi] ^ ctrl;

            rcas_full_adder u_fa (
                .a    (A[gi]),
                .b    (b_eff[gi]),
                .cin  (carry[gi]),
                .sum  (sum_next[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Result registers. Reset wins over a valid input.
    // When in_valid is low, the result holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                s_reg    <= sum_next;
                cout_reg <= carry[WIDTH];
            end
        end
    end

`ifdef RCAS_OVERFLOW_EN
    logic ovf_next;
    logic ovf_reg;

    // Signed overflow: the carry into the MSB differs from the carry out of it.
    assign ovf_next = carry[WIDTH] ^ carry[WIDTH-1];

    // Overflow loads, holds and resets exactly like Cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (in_valid) begin
            ovf_reg <= ovf_next;
        end
    end

    assign Overflow = ovf_reg;
`endif

    assign S         = s_reg;
    assign Cout      = cout_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_ripple_carry_adder_subtractor.sv
// Self-checking bench for ripple_carry_adder_subtractor.
// A table of hand-computed vectors runs on a WIDTH=4 instance.
// A mixed exhaustive/random phase then checks WIDTH=4 and WIDTH=8 instances
// against an integer-arithmetic reference model.

module tb_ripple_carry_adder_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       ctrl4 = 1'b0, valid4 = 1'b0, cout4, ovalid4;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       ctrl8 = 1'b0, valid8 = 1'b0, cout8, ovalid8;
`ifdef RCAS_OVERFLOW_EN
    logic       ovf4, ovf8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ripple_carry_adder_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .ctrl(ctrl4), .in_valid(valid4),
        .S(s4), .Cout(cout4),
`ifdef RCAS_OVERFLOW_EN
        .Overflow(ovf4),
`endif
        .out_valid(ovalid4)
    );

    ripple_carry_adder_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .ctrl(ctrl8), .in_valid(valid8),
        .S(s8), .Cout(cout8),
`ifdef RCAS_OVERFLOW_EN
        .Overflow(ovf8),
`endif
        .out_valid(ovalid8)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model built from arithmetic rules, independent of the gate structure.
    function automatic void ref_calc(input int w, input int a, input int b, input bit sub,
                                     output int s, output bit c, output bit ov);
        int m, sa, sb, r;
        m = 1 << w;
        if (!sub) begin
            s = (a + b) % m;
            c = (a + b) >= m;
        end else begin
            s = (a - b + m) % m;
            c = (a >= b);
        end
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        r  = sub ? sa - sb : sa + sb;
        ov = (r < -(m / 2)) || (r >= m / 2);
    endfunction

    typedef struct {
        string    name;
        bit       rst;
        bit       vld;
        bit       sub;
        bit [3:0] a;
        bit [3:0] b;
        bit [3:0] es;
        bit       ec;
        bit       ev;
        bit       eo;
    } vec_t;

    vec_t vecs[$];

    int   m_s4, m_s8;
    bit   m_c4, m_c8, m_o4, m_o8, m_v4, m_v8;
    int   ts;
    bit   tc, to;

    initial begin
        // name, rst, vld, sub, A, B, expected S, Cout, out_valid, Overflow
        vecs.push_back('{"reset",     1, 1, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0});
        vecs.push_back('{"add1+0",    0, 1, 0, 4'h1, 4'h0, 4'h1, 0, 1, 0});
        vecs.push_back('{"add2+4",    0, 1, 0, 4'h2, 4'h4, 4'h6, 0, 1, 0});
        vecs.push_back('{"addB+6",    0, 1, 0, 4'hB, 4'h6, 4'h1, 1, 1, 0});
        vecs.push_back('{"add5+3",    0, 1, 0, 4'h5, 4'h3, 4'h8, 0, 1, 1});
        vecs.push_back('{"sub1-0",    0, 1, 1, 4'h1, 4'h0, 4'h1, 1, 1, 0});
        vecs.push_back('{"sub2-4",    0, 1, 1, 4'h2, 4'h4, 4'hE, 0, 1, 0});
        vecs.push_back('{"subB-6",    0, 1, 1, 4'hB, 4'h6, 4'h5, 1, 1, 1});
        vecs.push_back('{"sub5-3",    0, 1, 1, 4'h5, 4'h3, 4'h2, 1, 1, 0});
        vecs.push_back('{"add5+3b",   0, 1, 0, 4'h5, 4'h3, 4'h8, 0, 1, 1});
        vecs.push_back('{"hold1",     0, 0, 1, 4'h7, 4'h2, 4'h8, 0, 0, 1});
        vecs.push_back('{"hold2",     0, 0, 0, 4'hF, 4'hF, 4'h8, 0, 0, 1});
        vecs.push_back('{"hold3",     0, 0, 1, 4'h0, 4'h9, 4'h8, 0, 0, 1});
        vecs.push_back('{"ms_add",    0, 1, 0, 4'h1, 4'h1, 4'h2, 0, 1, 0});
        vecs.push_back('{"ms_sub",    0, 1, 1, 4'h3, 4'h1, 4'h2, 1, 1, 0});
        vecs.push_back('{"ms_rst",    1, 1, 0, 4'h7, 4'h7, 4'h0, 0, 0, 0});
        vecs.push_back('{"ms_after",  0, 1, 1, 4'h4, 4'hC, 4'h8, 0, 1, 1});
        vecs.push_back('{"ms_next",   0, 1, 0, 4'h4, 4'h4, 4'h8, 0, 1, 1});
        vecs.push_back('{"subA=B",    0, 1, 1, 4'h9, 4'h9, 4'h0, 1, 1, 0});
        vecs.push_back('{"sub0-0",    0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 1, 0});
        vecs.push_back('{"addF+F",    0, 1, 0, 4'hF, 4'hF, 4'hE, 1, 1, 0});
        vecs.push_back('{"rst_hold0", 1, 0, 0, 4'h3, 4'h3, 4'h0, 0, 0, 0});
        vecs.push_back('{"hold0",     0, 0, 0, 4'h3, 4'h3, 4'h0, 0, 0, 0});

        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            valid4 = vecs[i].vld;
            ctrl4  = vecs[i].sub;
            a4     = vecs[i].a;
            b4     = vecs[i].b;
            @(posedge clk);
            #1;
            check({vecs[i].name, ".S"},     int'(s4),      int'(vecs[i].es));
            check({vecs[i].name, ".Cout"},  int'(cout4),   int'(vecs[i].ec));
            check({vecs[i].name, ".valid"}, int'(ovalid4), int'(vecs[i].ev));
`ifdef RCAS_OVERFLOW_EN
            check({vecs[i].name, ".Ovf"},   int'(ovf4),    int'(vecs[i].eo));
`endif
            $display("vec %0d %s: S=%h Cout=%0d out_valid=%0d", i, vecs[i].name, s4, cout4, ovalid4);
        end

        // Exhaustive 4-bit sweep for the first 512 cycles, then random operands.
        // The 8-bit instance gets random operands throughout.
        // The first cycle is a reset, so the model state starts out known.
        m_s4 = 0; m_c4 = 0; m_o4 = 0; m_v4 = 0;
        m_s8 = 0; m_c8 = 0; m_o8 = 0; m_v8 = 0;
        for (int i = 0; i < 4096; i++) begin
            rst = (i == 0) || ($urandom_range(63) == 0);
            if (i < 512) begin
                a4 = i[3:0];
                b4 = i[7:4];
                ctrl4 = i[8];
                valid4 = 1'b1;
            end else begin
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                ctrl4 = 1'($urandom);
                valid4 = ($urandom_range(7) != 0);
            end
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            ctrl8 = 1'($urandom);
            valid8 = ($urandom_range(7) != 0);
            @(posedge clk);
            #1;
            if (rst) begin
                m_s4 = 0; m_c4 = 0; m_o4 = 0; m_v4 = 0;
                m_s8 = 0; m_c8 = 0; m_o8 = 0; m_v8 = 0;
            end else begin
                m_v4 = valid4;
                if (valid4) begin
                    ref_calc(4, int'(a4), int'(b4), ctrl4, ts, tc, to);
                    m_s4 = ts; m_c4 = tc; m_o4 = to;
                end
                m_v8 = valid8;
                if (valid8) begin
                    ref_calc(8, int'(a8), int'(b8), ctrl8, ts, tc, to);
                    m_s8 = ts; m_c8 = tc; m_o8 = to;
                end
            end
            check("rnd4.S",     int'(s4),      m_s4);
            check("rnd4.Cout",  int'(cout4),   int'(m_c4));
            check("rnd4.valid", int'(ovalid4), int'(m_v4));
            check("rnd8.S",     int'(s8),      m_s8);
            check("rnd8.Cout",  int'(cout8),   int'(m_c8));
            check("rnd8.valid", int'(ovalid8), int'(m_v8));
`ifdef RCAS_OVERFLOW_EN
            check("rnd4.Ovf",   int'(ovf4),    int'(m_o4));
            check("rnd8.Ovf",   int'(ovf8),    int'(m_o8));
`endif
        end
        $display("random phase: 4096 cycles on WIDTH=4 and WIDTH=8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder_subtractor.md
Name: ripple_carry_adder_subtractor

Overview:
Parameterised two's-complement adder/subtractor built as an explicit ripple chain of full adders, with registered outputs. A single control bit selects the operation. When `ctrl`=1 the B operand is XOR-inverted and the chain carry-in is forced to 1, giving A − B. The block is a general arithmetic leaf used inside datapaths; it has one clock and one synchronous active-high reset.

Parameters:
WIDTH, 4, operand and result width in bits (≥1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
A  input  WIDTH  operand A, unsigned or two's complement
B  input  WIDTH  operand B, unsigned or two's complement
ctrl  input  1  0 = add (A+B), 1 = subtract (A−B)
in_valid  input  1  qualifies A/B/ctrl for capture this cycle
S  output  WIDTH  registered sum/difference
Cout  output  1  registered carry-out of the MSB full adder
out_valid  output  1  registered; high one cycle after an accepted input

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Datapath is combinational:
  - Bb[i] = B[i] XOR ctrl; c[0] = ctrl.
  - For each i: s[i] = A[i]^Bb[i]^c[i]; c[i+1] = majority(A[i], Bb[i], c[i]).
  - Must be a ripple chain of WIDTH full-adder stages (generate loop); no carry-lookahead.
- Add, `ctrl`=0: {Cout,S} = A + B, modulo 2^(WIDTH+1).
- Subtract, `ctrl`=1: S = (A − B) mod 2^WIDTH.
  - Cout = c[WIDTH] of A + ~B + 1, so Cout = 1 iff A ≥ B unsigned (no borrow).
  - Cout is not inverted to a borrow.
- Latency is 1 cycle. On a rising edge with `in_valid`=1:
  - S and Cout load the combinational result.
  - out_valid ← 1.
- On an edge with `in_valid`=0: S and Cout hold their previous values; out_valid ← 0.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- `rst`=1 at an edge takes priority over `in_valid`: S ← 0, Cout ← 0, out_valid ← 0. The optional Overflow output also ← 0.
- Reset asserted mid-stream discards the input presented in that cycle.
- Wrap-around:
  - Add overflow past 2^WIDTH−1: S wraps and Cout=1.
  - Subtract with A < B: S is the two's-complement negative and Cout=0.
- Edge cases:
  - A=B under subtract: S=0, Cout=1.
  - 0−0: S=0, Cout=1.
  - All-ones + all-ones: S = all-ones minus 1, Cout=1.
- No X propagation from in_valid=0 cycles: held values stay stable.

Optional Feature:
- Macro: RCAS_OVERFLOW_EN.
- When defined:
  - Adds port `Overflow`, output, width 1: registered signed overflow.
  - Overflow = c[WIDTH] XOR c[WIDTH−1], computed on the same effective operands, including the inverted B.
  - It loads, holds and resets exactly like Cout.
- When not defined: the port and its logic are absent, and the rest of the behaviour is unchanged.

Test Plan:
- Reset: assert `rst` with `in_valid`=1, A=4'hF, B=4'hF → next edge S=0000, Cout=0, out_valid=0 (Overflow=0 if enabled).
- Add sequence, `ctrl`=0, WIDTH=4, valid each cycle; responses one cycle later:
  - 0001+0000 → S=0001, Cout=0
  - 0010+0100 → S=0110, Cout=0
  - 1011+0110 → S=0001, Cout=1
  - 0101+0011 → S=1000, Cout=0 (Overflow=1)
- Subtract sequence, `ctrl`=1, same operands:
  - 0001−0000 → S=0001, Cout=1
  - 0010−0100 → S=1110, Cout=0 (Overflow=0)
  - 1011−0110 → S=0101, Cout=1 (Overflow=1)
  - 0101−0011 → S=0010, Cout=1
- Hold: after a valid 0101+0011, drop `in_valid` and change A/B for 3 cycles → S stays 1000, Cout stays 0, out_valid=0.
- Reset mid-stream: `in_valid`=1 with `ctrl` toggling each cycle, assert `rst` for one cycle → outputs 0 on that edge; the next valid input's result appears one cycle after `rst` deasserts.
- Exhaustive/random: for WIDTH=4 and WIDTH=8, all (or 10k random) A, B, `ctrl` combinations → {Cout,S} match the reference model A+B or A+~B+1, one cycle later.
